// File: rtl/move_sched_pkg.sv
// Shared op codes, FSM state encoding, pending-bit layout and gravity period table
// for the move scheduler.
package move_sched_pkg;

   localparam int unsigned OP_W     = 3;
   localparam int unsigned PERIOD_W = 6;
   localparam int unsigned NUM_REQ  = 6;

   typedef logic [OP_W-1:0] op_t;

   localparam op_t OP_NONE  = 3'd0;
   localparam op_t OP_LEFT  = 3'd1;
   localparam op_t OP_RIGHT = 3'd2;
   localparam op_t OP_CW    = 3'd3;
   localparam op_t OP_CCW   = 3'd4;
   localparam op_t OP_DROP  = 3'd5;
   localparam op_t OP_LOCK  = 3'd6;
   localparam op_t OP_SPAWN = 3'd7;

   // Pending-bit positions, highest grant priority at the top
   localparam int unsigned P_DOWN  = 0;
   localparam int unsigned P_RIGHT = 1;
   localparam int unsigned P_LEFT  = 2;
   localparam int unsigned P_CCW   = 3;
   localparam int unsigned P_CW    = 4;
   localparam int unsigned P_GRAV  = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SPAWN = 3'd1,
      ST_READY = 3'd2,
      ST_ISSUE = 3'd3,
      ST_LOCK  = 3'd4,
      ST_OVER  = 3'd5
   } state_t;

   function automatic logic [PERIOD_W-1:0] grav_period(input logic [1:0] level);
      case (level)
         2'b00:   return 6'd48;
         2'b01:   return 6'd24;
         2'b10:   return 6'd12;
         default: return 6'd6;
      endcase
   endfunction

   // Pending bits retired by an accepted op; DROP serves both gravity and DOWN
   function automatic logic [NUM_REQ-1:0] clr_mask(input op_t op);
      logic [NUM_REQ-1:0] m;
      m = '0;
      case (op)
         OP_LEFT:  m[P_LEFT]  = 1'b1;
         OP_RIGHT: m[P_RIGHT] = 1'b1;
         OP_CW:    m[P_CW]    = 1'b1;
         OP_CCW:   m[P_CCW]   = 1'b1;
         OP_DROP: begin
            m[P_GRAV] = 1'b1;
            m[P_DOWN] = 1'b1;
         end
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/gravity_timer.sv
// Counts video frames while running and emits a one-cycle tick once the
// level-dependent gravity period has elapsed.
module gravity_timer
   import move_sched_pkg::*;
#(
   parameter int unsigned FRAME_W = 6
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic [1:0] level,
   input  logic       run,
   input  logic       clear,
   output logic       tick
);

   logic [FRAME_W-1:0] count;
   logic [FRAME_W-1:0] limit;

   // >= rather than == so a faster level takes effect on the very next frame
   assign limit = FRAME_W'(grav_period(level) - PERIOD_W'(1));
   assign tick  = run & frame_start & (count >= limit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear | tick)
         count <= '0;
      else if (run & frame_start)
         count <= count + FRAME_W'(1);
   end

endmodule

// File: rtl/move_scheduler.sv
// Sequences player requests, gravity drops, lock and spawn operations toward the
// board engine, one op at a time over a valid/ready handshake.
module move_scheduler
   import move_sched_pkg::*;
#(
   parameter int unsigned FRAME_W = 6
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       frame_start,
   input  logic [1:0] level,
   input  logic       req_left,
   input  logic       req_right,
   input  logic       req_cw,
   input  logic       req_ccw,
   input  logic       req_down,
   output logic       op_valid,
   output op_t        op_code,
   input  logic       op_ready,
   input  logic       op_blocked,
   output logic       game_over
);

   state_t             state, state_d;
   logic               valid_d, over_d;
   op_t                code_d, grant_c;
   logic [NUM_REQ-1:0] pend, pend_d, req_set, req_clr;
   logic               tick, accept, drop_acc, run;

   assign accept   = op_valid & op_ready;
   assign run      = (state == ST_READY) | (state == ST_ISSUE);
   assign drop_acc = accept & (state == ST_ISSUE) & (op_code == OP_DROP);

   gravity_timer #(.FRAME_W(FRAME_W)) u_gravity_timer (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .level       (level),
      .run         (run),
      .clear       (drop_acc | (state == ST_IDLE)),
      .tick        (tick)
   );

   // Fixed-priority grant over the pending bits
   always_comb begin
      grant_c = OP_NONE;
      if      (pend[P_GRAV])  grant_c = OP_DROP;
      else if (pend[P_CW])    grant_c = OP_CW;
      else if (pend[P_CCW])   grant_c = OP_CCW;
      else if (pend[P_LEFT])  grant_c = OP_LEFT;
      else if (pend[P_RIGHT]) grant_c = OP_RIGHT;
      else if (pend[P_DOWN])  grant_c = OP_DROP;
   end

   // Pending bits: a new request in the accept cycle survives the clear
   always_comb begin
      req_set = '0;
      req_clr = '0;
      if (state != ST_OVER)
         req_set = {tick, req_cw, req_ccw, req_left, req_right, req_down};
      if (accept && (state == ST_ISSUE))
         req_clr = clr_mask(op_code);
      pend_d = (pend & ~req_clr) | req_set;
      if (!enable || (state == ST_IDLE))
         pend_d = '0;
   end

   always_comb begin
      state_d = state;
      valid_d = op_valid;
      code_d  = op_code;
      over_d  = game_over;
      case (state)
         ST_IDLE: begin
            valid_d = 1'b0;
            code_d  = OP_NONE;
            over_d  = 1'b0;
            if (enable) begin
               state_d = ST_SPAWN;
               valid_d = 1'b1;
               code_d  = OP_SPAWN;
            end
         end
         ST_SPAWN: begin
            if (accept) begin
               valid_d = 1'b0;
               code_d  = OP_NONE;
               if (op_blocked) begin
                  state_d = ST_OVER;
                  over_d  = 1'b1;
               end else begin
                  state_d = ST_READY;
               end
            end
         end
         ST_READY: begin
            if (grant_c != OP_NONE) begin
               state_d = ST_ISSUE;
               valid_d = 1'b1;
               code_d  = grant_c;
            end
         end
         ST_ISSUE: begin
            // Blocked moves and rotations are simply discarded
            if (accept) begin
               if ((op_code == OP_DROP) && op_blocked) begin
                  state_d = ST_LOCK;
                  valid_d = 1'b1;
                  code_d  = OP_LOCK;
               end else begin
                  state_d = ST_READY;
                  valid_d = 1'b0;
                  code_d  = OP_NONE;
               end
            end
         end
         ST_LOCK: begin
            if (accept) begin
               state_d = ST_SPAWN;
               valid_d = 1'b1;
               code_d  = OP_SPAWN;
            end
         end
         ST_OVER: begin
            valid_d = 1'b0;
            code_d  = OP_NONE;
            over_d  = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            code_d  = OP_NONE;
            over_d  = 1'b0;
         end
      endcase
      // Leaving play withdraws any offered op immediately
      if (!enable) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         code_d  = OP_NONE;
         over_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         op_valid  <= 1'b0;
         op_code   <= OP_NONE;
         game_over <= 1'b0;
         pend      <= '0;
      end else begin
         state     <= state_d;
         op_valid  <= valid_d;
         op_code   <= code_d;
         game_over <= over_d;
         pend      <= pend_d;
      end
   end

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: stimulus queues expected accepts and
// status probes by cycle, a negedge monitor checks them.
module tb_move_scheduler;

   localparam logic [2:0] T_NONE  = 3'd0;
   localparam logic [2:0] T_LEFT  = 3'd1;
   localparam logic [2:0] T_RIGHT = 3'd2;
   localparam logic [2:0] T_CW    = 3'd3;
   localparam logic [2:0] T_CCW   = 3'd4;
   localparam logic [2:0] T_DROP  = 3'd5;
   localparam logic [2:0] T_LOCK  = 3'd6;
   localparam logic [2:0] T_SPAWN = 3'd7;

   typedef struct {
      logic [2:0] op;
      int         cyc;
   } exp_op_t;

   typedef struct {
      int         cyc;
      logic       v;
      logic [2:0] code;
      logic       over;
   } probe_t;

   logic       clk = 1'b0;
   logic       reset, enable, frame_start;
   logic [1:0] level;
   logic       req_left, req_right, req_cw, req_ccw, req_down;
   logic       op_valid, op_ready, op_blocked, game_over;
   logic [2:0] op_code;

   exp_op_t op_q[$];
   probe_t  probe_q[$];
   int      cyc = 0;
   int      n_tests = 0;
   int      n_fail = 0;
   logic    done = 1'b0;
   logic    prev_hold = 1'b0;
   logic [2:0] prev_code = 3'd0;
   exp_op_t e;
   probe_t  p;
   int      n, m;

   move_scheduler #(.FRAME_W(6)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .frame_start (frame_start),
      .level       (level),
      .req_left    (req_left),
      .req_right   (req_right),
      .req_cw      (req_cw),
      .req_ccw     (req_ccw),
      .req_down    (req_down),
      .op_valid    (op_valid),
      .op_code     (op_code),
      .op_ready    (op_ready),
      .op_blocked  (op_blocked),
      .game_over   (game_over)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic exp_op(input logic [2:0] op, input int c);
      exp_op_t x;
      x.op = op;
      x.cyc = c;
      op_q.push_back(x);
   endtask

   task automatic probe(input int c, input logic v, input logic [2:0] code, input logic over);
      probe_t x;
      x.cyc = c;
      x.v = v;
      x.code = code;
      x.over = over;
      probe_q.push_back(x);
   endtask

   task automatic frame();
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
      step(3);
   endtask

   task automatic frames(input int k);
      for (int i = 0; i < k; i++) frame();
   endtask

   // Monitor: probes, accepted ops, handshake stability, end-of-run drain
   always @(negedge clk) begin
      if (done) begin
         n_tests++;
         if (op_q.size() != 0 || probe_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: ops left %0d probes left %0d, required 0/0", op_q.size(), probe_q.size());
         end
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
         $finish;
      end
      while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
         p = probe_q.pop_front();
         n_tests++;
         if (p.cyc != cyc || op_valid !== p.v || op_code !== p.code || game_over !== p.over) begin
            n_fail++;
            $display("FAIL probe@%0d (seen @%0d): valid/code/over=%0b/%0d/%0b required %0b/%0d/%0b",
                     p.cyc, cyc, op_valid, op_code, game_over, p.v, p.code, p.over);
         end
      end
      if (!reset && op_valid === 1'b1 && op_ready === 1'b1) begin
         n_tests++;
         if (op_q.size() == 0) begin
            n_fail++;
            $display("FAIL accept@%0d: unexpected op %0d, required none", cyc, op_code);
         end else begin
            e = op_q.pop_front();
            if (op_code !== e.op || (e.cyc >= 0 && e.cyc != cyc)) begin
               n_fail++;
               $display("FAIL accept: op %0d at cycle %0d, required op %0d at cycle %0d",
                        op_code, cyc, e.op, e.cyc);
            end
         end
      end
      if (prev_hold) begin
         n_tests++;
         if (op_valid !== 1'b1 || op_code !== prev_code) begin
            n_fail++;
            $display("FAIL hold@%0d: valid/code=%0b/%0d, required 1/%0d", cyc, op_valid, op_code, prev_code);
         end
      end
      prev_hold = !reset && op_valid === 1'b1 && op_ready === 1'b0 && enable === 1'b1;
      prev_code = op_code;
   end

   initial begin
      reset = 1'b1; enable = 1'b0; frame_start = 1'b0; level = 2'b00;
      req_left = 1'b0; req_right = 1'b0; req_cw = 1'b0; req_ccw = 1'b0; req_down = 1'b0;
      op_ready = 1'b0; op_blocked = 1'b0;
      step(1);
      probe(cyc, 1'b0, T_NONE, 1'b0);
      step(2);
      reset = 1'b0;
      step(1);
      probe(cyc, 1'b0, T_NONE, 1'b0);

      // Spawn, then gravity at level 00 fires only on the 48th frame
      op_ready = 1'b1; enable = 1'b1; n = cyc;
      exp_op(T_SPAWN, n + 1);
      step(2);
      frames(47);
      exp_op(T_DROP, cyc + 2);
      frame();

      // CW beats LEFT; LEFT two cycles after the CW accept
      n = cyc; req_left = 1'b1; req_cw = 1'b1;
      exp_op(T_CW, n + 2); exp_op(T_LEFT, n + 4);
      step(1); req_left = 1'b0; req_cw = 1'b0;
      step(6);

      // CCW > RIGHT > DOWN
      n = cyc; req_ccw = 1'b1; req_right = 1'b1; req_down = 1'b1;
      exp_op(T_CCW, n + 2); exp_op(T_RIGHT, n + 4); exp_op(T_DROP, n + 6);
      step(1); req_ccw = 1'b0; req_right = 1'b0; req_down = 1'b0;
      step(8);

      // Repeated pulses merge; a pulse in the accept cycle re-arms
      n = cyc; req_left = 1'b1;
      exp_op(T_LEFT, n + 2); exp_op(T_LEFT, n + 4);
      step(3); req_left = 1'b0;
      step(5);

      // Stalled LEFT stays stable; RIGHT follows
      n = cyc; op_ready = 1'b0; req_left = 1'b1;
      exp_op(T_LEFT, n + 12); exp_op(T_RIGHT, n + 14);
      probe(n + 7, 1'b1, T_LEFT, 1'b0);
      step(1); req_left = 1'b0;
      step(2); req_right = 1'b1;
      step(1); req_right = 1'b0;
      step(8); op_ready = 1'b1;
      step(5);

      // Blocked DROP -> LOCK -> SPAWN; gravity count restarts from 0
      frames(10);
      n = cyc; req_down = 1'b1;
      exp_op(T_DROP, n + 2); exp_op(T_LOCK, n + 3); exp_op(T_SPAWN, n + 4);
      step(1); req_down = 1'b0;
      step(1); op_blocked = 1'b1;
      step(1); op_blocked = 1'b0;
      step(3);
      frames(47);
      exp_op(T_DROP, cyc + 2);
      frame();

      // Level 00 -> 11 with count at 20
      frames(20);
      level = 2'b11;
      step(1);
      exp_op(T_DROP, cyc + 2);
      frame();
      frames(5);
      exp_op(T_DROP, cyc + 2);
      frame();
      frames(5);
      exp_op(T_DROP, cyc + 2);
      frame();

      // Blocked SPAWN -> game over; requests ignored; enable low clears
      n = cyc; req_down = 1'b1;
      exp_op(T_DROP, n + 2); exp_op(T_LOCK, n + 3); exp_op(T_SPAWN, n + 4);
      probe(n + 5, 1'b0, T_NONE, 1'b1);
      step(1); req_down = 1'b0;
      step(1); op_blocked = 1'b1;
      step(3); op_blocked = 1'b0;
      req_left = 1'b1; req_cw = 1'b1; req_down = 1'b1;
      step(1); req_left = 1'b0; req_cw = 1'b0; req_down = 1'b0;
      frames(15);
      probe(cyc, 1'b0, T_NONE, 1'b1);
      m = cyc; enable = 1'b0;
      probe(m + 1, 1'b0, T_NONE, 1'b0);
      step(2);

      // Offered SPAWN withdrawn by enable low
      n = cyc; op_ready = 1'b0; enable = 1'b1;
      probe(n + 1, 1'b1, T_SPAWN, 1'b0);
      step(2); enable = 1'b0;
      probe(cyc + 1, 1'b0, T_NONE, 1'b0);
      step(2);

      // Clean restart
      n = cyc; op_ready = 1'b1; enable = 1'b1;
      exp_op(T_SPAWN, n + 1);
      probe(n + 2, 1'b0, T_NONE, 1'b0);
      step(6);
      done = 1'b1;
   end

endmodule
